// File: rtl/output_block_vc_param.sv
// Router output block: drives the granted flit onto the link and tracks downstream
// credits, per-VC packet ownership and sticky error flags.
module output_block_vc_param #(
  parameter int unsigned NUM_VCS        = 4,
  parameter int unsigned CREDITS_PER_VC = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned OUT_REG        = 1,
  parameter int unsigned VCID_W         = $clog2(NUM_VCS),
  parameter int unsigned CTR_W          = $clog2(CREDITS_PER_VC + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ob_en,
  input  logic [2:0]                 flit_in_type,
  input  logic [VCID_W-1:0]          flit_in_vcid,
  input  logic [DATA_W-1:0]          flit_in_data,
  input  logic [NUM_VCS-1:0]         credit_in,
  output logic [2:0]                 flit_out_type,
  output logic [VCID_W-1:0]          flit_out_vcid,
  output logic [DATA_W-1:0]          flit_out_data,
  output logic [NUM_VCS*CTR_W-1:0]   credits_avail,
  output logic [NUM_VCS-1:0]         vc_has_credit,
  output logic [NUM_VCS-1:0]         vc_busy,
  output logic                       err_underflow,
  output logic                       err_overflow,
  output logic                       err_protocol,
  input  logic                       clr_err
);

  localparam logic [2:0] FT_I  = 3'd0;
  localparam logic [2:0] FT_H  = 3'd1;
  localparam logic [2:0] FT_B  = 3'd2;
  localparam logic [2:0] FT_T  = 3'd3;
  localparam logic [2:0] FT_HT = 3'd4;
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(CREDITS_PER_VC);

  typedef enum logic {VC_FREE = 1'b0, VC_ACTIVE = 1'b1} vc_state_t;

  vc_state_t          vc_state_q [NUM_VCS];
  vc_state_t          vc_state_d [NUM_VCS];
  logic [CTR_W-1:0]   cnt_q      [NUM_VCS];
  logic [CTR_W-1:0]   cnt_d      [NUM_VCS];
  logic [NUM_VCS-1:0] grant_v;
  logic [NUM_VCS-1:0] seq_err_v;
  logic [NUM_VCS-1:0] unf_v;
  logic [NUM_VCS-1:0] ovf_v;
  logic               type_ok;
  logic               vcid_ok;
  logic               accept;
  logic               drop;

  // Only data flits aimed at an existing VC are accepted; anything else is dropped
  assign type_ok = (flit_in_type == FT_H) || (flit_in_type == FT_B) ||
                   (flit_in_type == FT_T) || (flit_in_type == FT_HT);
  assign vcid_ok = 32'(flit_in_vcid) < NUM_VCS;
  assign accept  = ob_en & type_ok & vcid_ok;
  assign drop    = ob_en & ~accept;

  always_comb begin
    grant_v = '0;
    for (int v = 0; v < int'(NUM_VCS); v++) begin
      grant_v[v] = accept && (flit_in_vcid == VCID_W'(v));
    end
  end

  // Per-VC credit counter and ownership next state
  always_comb begin
    seq_err_v = '0;
    unf_v     = '0;
    ovf_v     = '0;
    for (int v = 0; v < int'(NUM_VCS); v++) begin
      vc_state_d[v] = vc_state_q[v];
      cnt_d[v]      = cnt_q[v];
      case ({grant_v[v], credit_in[v]})
        2'b01: begin
          if (cnt_q[v] == CTR_MAX) ovf_v[v] = 1'b1;
          else                     cnt_d[v] = cnt_q[v] + CTR_W'(1);
        end
        2'b10: begin
          if (cnt_q[v] == '0) unf_v[v] = 1'b1;
          else                cnt_d[v] = cnt_q[v] - CTR_W'(1);
        end
        default: ;
      endcase
      if (grant_v[v]) begin
        case (flit_in_type)
          FT_H: begin
            if (vc_state_q[v] == VC_ACTIVE) seq_err_v[v] = 1'b1;
            else                            vc_state_d[v] = VC_ACTIVE;
          end
          FT_HT: if (vc_state_q[v] == VC_ACTIVE) seq_err_v[v] = 1'b1;
          FT_B:  if (vc_state_q[v] == VC_FREE)   seq_err_v[v] = 1'b1;
          FT_T: begin
            if (vc_state_q[v] == VC_ACTIVE) vc_state_d[v] = VC_FREE;
            else                            seq_err_v[v] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < int'(NUM_VCS); v++) begin
        vc_state_q[v] <= VC_FREE;
        cnt_q[v]      <= CTR_MAX;
      end
      vc_has_credit <= '1;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      err_protocol  <= 1'b0;
    end else begin
      for (int v = 0; v < int'(NUM_VCS); v++) begin
        vc_state_q[v]    <= vc_state_d[v];
        cnt_q[v]         <= cnt_d[v];
        vc_has_credit[v] <= (cnt_d[v] != '0);
      end
      // A new error in the clearing cycle wins over the clear
      err_underflow <= (err_underflow & ~clr_err) | (|unf_v);
      err_overflow  <= (err_overflow  & ~clr_err) | (|ovf_v);
      err_protocol  <= (err_protocol  & ~clr_err) | (|seq_err_v) | drop;
    end
  end

  always_comb begin
    credits_avail = '0;
    vc_busy       = '0;
    for (int v = 0; v < int'(NUM_VCS); v++) begin
      credits_avail[v*CTR_W +: CTR_W] = cnt_q[v];
      vc_busy[v]                      = (vc_state_q[v] == VC_ACTIVE);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Idle cycles send I but keep vcid/data stable to avoid link toggling
      always_ff @(posedge clk) begin
        if (rst) begin
          flit_out_type <= FT_I;
          flit_out_vcid <= '0;
          flit_out_data <= '0;
        end else if (accept) begin
          flit_out_type <= flit_in_type;
          flit_out_vcid <= flit_in_vcid;
          flit_out_data <= flit_in_data;
        end else begin
          flit_out_type <= FT_I;
        end
      end
    end else begin : g_out_comb
      always_comb begin
        flit_out_type = accept ? flit_in_type : FT_I;
        flit_out_vcid = accept ? flit_in_vcid : '0;
        flit_out_data = accept ? flit_in_data : '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_output_block_vc_param.sv
// Bench for output_block_vc_param: registered and pass-through instances driven in
// parallel, compared every cycle against a behavioural credit/ownership model.
module tb_output_block_vc_param;

  localparam int NV  = 4;
  localparam int CPV = 4;
  localparam int DW  = 32;
  localparam int VW  = 2;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst, ob_en, clr_err;
  logic [2:0]    flit_in_type;
  logic [VW-1:0] flit_in_vcid;
  logic [DW-1:0] flit_in_data;
  logic [NV-1:0] credit_in;

  logic [2:0]       r_type, c_type;
  logic [VW-1:0]    r_vcid, c_vcid;
  logic [DW-1:0]    r_data, c_data;
  logic [NV*CW-1:0] r_cred, c_cred;
  logic [NV-1:0]    r_hasc, c_hasc, r_busy, c_busy;
  logic             r_un, r_ov, r_pr, c_un, c_ov, c_pr;

  // Reference model state
  int            m_cred [NV];
  bit            m_busy [NV];
  bit            m_un, m_ov, m_pr;
  logic [2:0]    m_type;
  logic [VW-1:0] m_vcid;
  logic [DW-1:0] m_data;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  output_block_vc_param #(.NUM_VCS(NV), .CREDITS_PER_VC(CPV), .DATA_W(DW), .OUT_REG(1)) dut_reg (
    .clk(clk), .rst(rst), .ob_en(ob_en), .flit_in_type(flit_in_type), .flit_in_vcid(flit_in_vcid),
    .flit_in_data(flit_in_data), .credit_in(credit_in), .flit_out_type(r_type), .flit_out_vcid(r_vcid),
    .flit_out_data(r_data), .credits_avail(r_cred), .vc_has_credit(r_hasc), .vc_busy(r_busy),
    .err_underflow(r_un), .err_overflow(r_ov), .err_protocol(r_pr), .clr_err(clr_err));

  output_block_vc_param #(.NUM_VCS(NV), .CREDITS_PER_VC(CPV), .DATA_W(DW), .OUT_REG(0)) dut_comb (
    .clk(clk), .rst(rst), .ob_en(ob_en), .flit_in_type(flit_in_type), .flit_in_vcid(flit_in_vcid),
    .flit_in_data(flit_in_data), .credit_in(credit_in), .flit_out_type(c_type), .flit_out_vcid(c_vcid),
    .flit_out_data(c_data), .credits_avail(c_cred), .vc_has_credit(c_hasc), .vc_busy(c_busy),
    .err_underflow(c_un), .err_overflow(c_ov), .err_protocol(c_pr), .clr_err(clr_err));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NV*CW-1:0] model_cred_packed();
    logic [NV*CW-1:0] p;
    p = '0;
    for (int v = 0; v < NV; v++) p[v*CW +: CW] = CW'(m_cred[v]);
    return p;
  endfunction

  function automatic logic [NV-1:0] model_vec(input bit sel_busy);
    logic [NV-1:0] p;
    for (int v = 0; v < NV; v++) p[v] = sel_busy ? m_busy[v] : (m_cred[v] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_cred[v] = CPV;
      m_busy[v] = 1'b0;
    end
    {m_un, m_ov, m_pr} = 3'b000;
    m_type = 3'd0;
    m_vcid = '0;
    m_data = '0;
  endtask

  task automatic check_state();
    chk("out_type",   64'(r_type), 64'(m_type));
    chk("out_vcid",   64'(r_vcid), 64'(m_vcid));
    chk("out_data",   64'(r_data), 64'(m_data));
    chk("credits",    64'(r_cred), 64'(model_cred_packed()));
    chk("has_credit", 64'(r_hasc), 64'(model_vec(1'b0)));
    chk("busy",       64'(r_busy), 64'(model_vec(1'b1)));
    chk("errors",     64'({r_un, r_ov, r_pr}), 64'({m_un, m_ov, m_pr}));
    chk("comb_state", 64'({c_cred, c_busy, c_un, c_ov, c_pr}),
        64'({model_cred_packed(), model_vec(1'b1), m_un, m_ov, m_pr}));
  endtask

  // One clock: drive inputs, check pass-through outputs, clock, update model, check
  task automatic step(input bit r, input bit en, input logic [2:0] ty, input logic [VW-1:0] vc,
                      input logic [DW-1:0] d, input logic [NV-1:0] cr, input bit clr);
    bit acc, pr_n, un_n, ov_n, g;
    rst = r; ob_en = en; flit_in_type = ty; flit_in_vcid = vc;
    flit_in_data = d; credit_in = cr; clr_err = clr;
    acc = en && (ty >= 3'd1) && (ty <= 3'd4) && (int'(vc) < NV);
    #1;
    chk("comb_type", 64'(c_type), 64'(acc ? ty : 3'd0));
    chk("comb_vcid", 64'(c_vcid), 64'(acc ? vc : '0));
    chk("comb_data", 64'(c_data), 64'(acc ? d : '0));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      pr_n = en && !acc;
      un_n = 1'b0;
      ov_n = 1'b0;
      for (int v = 0; v < NV; v++) begin
        g = acc && (int'(vc) == v);
        if (g && !cr[v]) begin
          if (m_cred[v] == 0) un_n = 1'b1; else m_cred[v] = m_cred[v] - 1;
        end else if (!g && cr[v]) begin
          if (m_cred[v] == CPV) ov_n = 1'b1; else m_cred[v] = m_cred[v] + 1;
        end
        if (g) begin
          case (ty)
            3'd1: if (m_busy[v]) pr_n = 1'b1; else m_busy[v] = 1'b1;
            3'd2: if (!m_busy[v]) pr_n = 1'b1;
            3'd3: if (m_busy[v]) m_busy[v] = 1'b0; else pr_n = 1'b1;
            3'd4: if (m_busy[v]) pr_n = 1'b1;
            default: ;
          endcase
        end
      end
      m_un = (m_un && !clr) || un_n;
      m_ov = (m_ov && !clr) || ov_n;
      m_pr = (m_pr && !clr) || pr_n;
      if (acc) begin
        m_type = ty; m_vcid = vc; m_data = d;
      end else begin
        m_type = 3'd0;
      end
    end
    #1;
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [2:0]    ty;
    logic [NV-1:0] cr;
    model_reset();
    step(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    idle(3);
    chk("reset_credits", 64'(r_cred), 64'({4{3'd4}}));
    chk("reset_idle", 64'({r_type, r_busy, r_un, r_ov, r_pr}), 64'(0));

    // H/B/T packet on VC2
    step(1'b0, 1'b1, 3'd1, 2'd2, 32'hA5A5_A5A5, '0, 1'b0);
    chk("h_out", 64'({r_type, r_vcid, r_data}), 64'({3'd1, 2'd2, 32'hA5A5_A5A5}));
    step(1'b0, 1'b1, 3'd2, 2'd2, 32'h1111_2222, '0, 1'b0);
    step(1'b0, 1'b1, 3'd3, 2'd2, 32'h3333_4444, '0, 1'b0);
    chk("vc2_after_t", 64'({r_cred[8:6], r_busy[2]}), 64'({3'd1, 1'b0}));

    // Drain VC0 to zero then underflow
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd4, 2'd0, DW'(i), '0, 1'b0);
    chk("vc0_underflow", 64'({r_cred[2:0], r_hasc[0], r_un, r_type}), 64'({3'd0, 1'b0, 1'b1, 3'd4}));

    // Grant with simultaneous credit at full and at empty, then overflow on VC3
    step(1'b0, 1'b1, 3'd4, 2'd1, 32'h5, 4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd4, 2'd1, 32'h6, '0, 1'b0);
    step(1'b0, 1'b1, 3'd4, 2'd1, 32'h7, 4'b0010, 1'b0);
    step(1'b0, 1'b0, 3'd0, '0, '0, 4'b1000, 1'b0);
    chk("vc3_overflow", 64'({r_cred[11:9], r_ov}), 64'({3'd4, 1'b1}));

    // Protocol errors then clear
    step(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b1);
    step(1'b0, 1'b1, 3'd2, 2'd3, 32'hBEEF, '0, 1'b0);
    step(1'b0, 1'b1, 3'd0, 2'd0, 32'hDEAD, '0, 1'b0);
    step(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b1);
    chk("cleared", 64'({r_un, r_ov, r_pr}), 64'(0));

    // Refill VC1 to 3, open a packet, reset mid-packet
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, '0, '0, 4'b0010, 1'b0);
    step(1'b0, 1'b1, 3'd1, 2'd1, 32'hCAFE_F00D, '0, 1'b0);
    chk("vc1_active", 64'({r_cred[5:3], r_busy[1]}), 64'({3'd2, 1'b1}));
    step(1'b1, 1'b1, 3'd2, 2'd1, 32'h0, '0, 1'b0);
    chk("vc1_reset", 64'({r_cred[5:3], r_busy[1]}), 64'({3'd4, 1'b0}));

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      ty = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
      for (int v = 0; v < NV; v++) cr[v] = ($urandom_range(0, 99) < 22);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), ty, VW'($urandom),
           DW'($urandom), cr, ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/output_block_vc_param.md
Name: output_block_vc_param

Overview:
- Parametrised next-generation router output block. Sits between the switch-traversal stage and the output link.
- Registers the granted flit onto the link and keeps one credit counter per downstream VC.
- Tracks per-VC packet ownership (free/active) so the VC allocator sees downstream VC occupancy.
- Detects and records credit and protocol violations in sticky error flags.

Parameters:
- NUM_VCS, 4, number of virtual channels per port (≥2)
- CREDITS_PER_VC, 4, downstream buffer depth per VC (≥1)
- DATA_W, 32, flit payload width
- OUT_REG, 1, 1 = flit output registered (1-cycle latency); 0 = combinational pass-through
- VCID_W, $clog2(NUM_VCS), VC id width (derived)
- CTR_W, $clog2(CREDITS_PER_VC+1), credit counter width (derived)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous reset, active-high
- ob_en  in  1  switch grant: flit_in valid this cycle
- flit_in_type  in  3  I=0, H=1, B=2, T=3, HT=4 (single-flit packet); 5–7 illegal
- flit_in_vcid  in  VCID_W  target downstream VC
- flit_in_data  in  DATA_W  payload
- credit_in  in  NUM_VCS  one-hot-per-VC credit return, 1 credit per asserted bit
- flit_out_type  out  3  link flit type
- flit_out_vcid  out  VCID_W  link VC id
- flit_out_data  out  DATA_W  link payload
- credits_avail  out  NUM_VCS*CTR_W  packed registered counters, VC0 in LSBs
- vc_has_credit  out  NUM_VCS  credits_avail[v] != 0
- vc_busy  out  NUM_VCS  VC owned by an in-flight packet
- err_underflow  out  1  sticky
- err_overflow  out  1  sticky
- err_protocol  out  1  sticky
- clr_err  in  1  clears all sticky errors next cycle

Behaviour:
- Reset (rst high at clk edge) sets:
  - flit_out_type=I, flit_out_vcid=0, flit_out_data=0
  - credits_avail[v]=CREDITS_PER_VC, vc_busy=0, all error flags 0
- Reset mid-packet discards all state; no partial recovery.
- Accepted flit: ob_en=1, type ∈ {H,B,T,HT}, vcid < NUM_VCS.
- Forwarding, OUT_REG=1:
  - Accepted flit appears on flit_out_* the next cycle.
  - Otherwise flit_out_type=I next cycle, and vcid/data hold their last value.
- Forwarding, OUT_REG=0: flit_out_* follow flit_in_* combinationally when accepted; else type=I, vcid/data=0.
- ob_en=1 with type I, type 5–7, or vcid ≥ NUM_VCS: flit dropped (not forwarded, no counter or state change), err_protocol set.
- Credit counter per VC v (g = accepted flit on v, c = credit_in[v]), next-cycle update:
  - g=0, c=0: hold
  - g=0, c=1: +1; if already CREDITS_PER_VC, hold and set err_overflow
  - g=1, c=0: −1; if already 0, hold at 0, set err_underflow, flit still forwarded
  - g=1, c=1: hold, no error, including at count 0 or full
- Counters never wrap.
- VC state per VC, FREE (vc_busy=0) / ACTIVE (vc_busy=1), updated next cycle:
  - FREE + H → ACTIVE
  - FREE + HT → FREE
  - FREE + B or T → stays FREE, err_protocol
  - ACTIVE + B → ACTIVE
  - ACTIVE + T → FREE
  - ACTIVE + H or HT → stays ACTIVE, err_protocol
- Flits causing these protocol errors are still forwarded and still consume credit.
- Error flags:
  - Set and clear take effect the cycle after the event.
  - If clr_err and a new error occur in the same cycle, set wins.
- vc_has_credit is derived from the registered counters: no combinational path from credit_in.
- Multiple credit_in bits may be high in one cycle; each VC is independent.

Test Plan:
- Reset, then idle 3 cycles → credits_avail all 4, vc_busy=0, flit_out_type=I, errors 0.
- H on VC2 with data 0xA5A5A5A5, then B, then T on consecutive cycles (OUT_REG=1) → out one cycle later with matching type/data; credits_avail[2] 3→2→1; vc_busy[2]=1 after H, 0 after T.
- 4 HT flits on VC0 with no credits returned, then a 5th → count reaches 0, vc_has_credit[0]=0; 5th flit forwarded, err_underflow=1, count stays 0.
- Grant on VC1 with credit_in[1]=1 in the same cycle, at count 4 and again at count 0 → count unchanged, no error; credit_in[3] at count 4 → err_overflow=1, count stays 4.
- Protocol errors:
  - B on free VC3 → forwarded, err_protocol=1, vc_busy[3]=0.
  - ob_en=1 with type I → no output, err_protocol=1.
  - clr_err → all flags 0 next cycle.
- OUT_REG=0 H on VC1 → flit_out_* match inputs in the same cycle.
- Reset asserted while VC1 is ACTIVE with count 2 → next cycle count 4, vc_busy[1]=0.
